// File: rtl/adder_sequencer.sv
// Load/accumulate sequencer for the 16-bit CLA adder datapath: one B-register load per button press.
// Optional ADDER_SAT_EN saturates the captured sum to 17'h1FFFF on carry-out.
module adder_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LoadB,
  input  logic        Run,
  input  logic [15:0] SW,
  input  logic [15:0] Sum,
  input  logic        C_out,
  output logic        Ld_B,
  output logic [16:0] to_reg,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = DATA_W + 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lb_meta_q, lb_meta_d, lb_s_q, lb_s_d;
  logic               run_meta_q, run_meta_d, run_s_q, run_s_d;
  logic               ld_b_q, ld_b_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [REG_W-1:0]   to_reg_c;

  // Two-flop synchronisers for the push-button requests
  always_comb begin
    lb_meta_d  = LoadB;
    lb_s_d     = lb_meta_q;
    run_meta_d = Run;
    run_s_d    = run_meta_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lb_meta_q  <= 1'b0;
      lb_s_q     <= 1'b0;
      run_meta_q <= 1'b0;
      run_s_q    <= 1'b0;
      ld_b_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lb_meta_q  <= lb_meta_d;
      lb_s_q     <= lb_s_d;
      run_meta_q <= run_meta_d;
      run_s_q    <= run_s_d;
      ld_b_q     <= ld_b_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next state; Ld_B and busy are registered from the next state so they track state_q exactly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (lb_s_q) begin
          state_d = LOAD;
        end else if (run_s_q) begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
        end
      end
      LOAD: begin
        state_d = HOLD;
        ovf_d   = 1'b0;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_d = HOLD;
        if (C_out) begin
          ovf_d = 1'b1;
        end
      end
      HOLD: begin
        if (!lb_s_q && !run_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ld_b_d = (state_d == LOAD) || (state_d == CAPTURE);
    busy_d = (state_d == LOAD) || (state_d == SETTLE) || (state_d == CAPTURE);
  end

  // Register data is decoded from state; Sum/C_out are only looked at in CAPTURE
  always_comb begin
    to_reg_c = '0;
    if (state_q == LOAD) begin
      to_reg_c = {1'b0, SW};
    end else if (state_q == CAPTURE) begin
`ifdef ADDER_SAT_EN
      to_reg_c = C_out ? {REG_W{1'b1}} : {1'b0, Sum};
`else
      to_reg_c = {C_out, Sum};
`endif
    end
  end

  assign Ld_B   = ld_b_q;
  assign busy   = busy_q;
  assign ovf    = ovf_q;
  assign to_reg = to_reg_c;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed bench for adder_sequencer: three instances (SETTLE_CYCLES 2, 1, 15) share stimulus.
module tb_adder_sequencer;

  logic        Clk;
  logic        Reset;
  logic        LoadB;
  logic        Run;
  logic [15:0] SW;
  logic [15:0] Sum;
  logic        C_out;
  logic [2:0]  ld_w;
  logic [2:0]  busy_w;
  logic [2:0]  ovf_w;
  logic [16:0] treg_w [3];

  int          checks;
  int          errors;
  int          pulses [3];
  int          first_cyc [3];
  int          consec [3];
  logic [16:0] val [3];
  logic [2:0]  prev_ld;
  int          busy_cnt;
  logic [16:0] exp_v;

  adder_sequencer #(.SETTLE_CYCLES(2)) dut0 (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .SW(SW), .Sum(Sum), .C_out(C_out),
    .Ld_B(ld_w[0]), .to_reg(treg_w[0]), .busy(busy_w[0]), .ovf(ovf_w[0]));

  adder_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .SW(SW), .Sum(Sum), .C_out(C_out),
    .Ld_B(ld_w[1]), .to_reg(treg_w[1]), .busy(busy_w[1]), .ovf(ovf_w[1]));

  adder_sequencer #(.SETTLE_CYCLES(15)) dut15 (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .SW(SW), .Sum(Sum), .C_out(C_out),
    .Ld_B(ld_w[2]), .to_reg(treg_w[2]), .busy(busy_w[2]), .ovf(ovf_w[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Cycle k is the interval after rising edge k, counted from the negedge where inputs changed
  task automatic observe(input int ncyc, input int base);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      for (int d = 0; d < 3; d++) begin
        if (ld_w[d]) begin
          if (pulses[d] == 0) begin
            first_cyc[d] = base + k;
            val[d]       = treg_w[d];
          end
          pulses[d]++;
          if (prev_ld[d]) consec[d]++;
        end
        prev_ld[d] = ld_w[d];
      end
      if (busy_w[0]) busy_cnt++;
    end
  endtask

  task automatic press(input logic lb, input logic rn, input int hold);
    for (int d = 0; d < 3; d++) begin
      pulses[d]    = 0;
      first_cyc[d] = -1;
      val[d]       = '0;
    end
    busy_cnt = 0;
    @(negedge Clk);
    LoadB = lb;
    Run   = rn;
    observe(hold, 0);
    LoadB = 1'b0;
    Run   = 1'b0;
    observe(6, hold);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    LoadB = 1'b0;
    Run   = 1'b0;
    SW    = '0;
    Sum   = '0;
    C_out = 1'b0;
    prev_ld = '0;
    for (int d = 0; d < 3; d++) consec[d] = 0;
    #1;
    checks++;
    if (ld_w !== 3'b000 || busy_w !== 3'b000 || ovf_w !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: ld=%b busy=%b ovf=%b want 000/000/000", ld_w, busy_w, ovf_w);
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (treg_w[d] !== 17'h00000) begin
        errors++;
        $display("FAIL reset_to_reg[%0d]: got %h want 00000", d, treg_w[d]);
      end
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (busy_w !== 3'b000 || ld_w !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b ld=%b want 000/000", busy_w, ld_w);
    end
  endtask

  task automatic test_load;
    SW = 16'h1234;
    press(1'b1, 1'b0, 5);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pulses[d] !== 1 || first_cyc[d] !== 3 || val[d] !== 17'h01234) begin
        errors++;
        $display("FAIL load[%0d]: pulses=%0d cyc=%0d to_reg=%h want 1/3/01234", d, pulses[d], first_cyc[d], val[d]);
      end
    end
    checks++;
    if (busy_cnt !== 1 || ovf_w !== 3'b000) begin
      errors++;
      $display("FAIL load_busy_ovf: busy_cycles=%0d ovf=%b want 1/000", busy_cnt, ovf_w);
    end
  endtask

  task automatic test_accumulate;
    Sum   = 16'h1235;
    C_out = 1'b0;
    press(1'b0, 1'b1, 20);
    checks++;
    if (pulses[0] !== 1 || first_cyc[0] !== 5 || val[0] !== 17'h01235) begin
      errors++;
      $display("FAIL acc_n2: pulses=%0d cyc=%0d to_reg=%h want 1/5/01235", pulses[0], first_cyc[0], val[0]);
    end
    checks++;
    if (pulses[1] !== 1 || first_cyc[1] !== 4 || val[1] !== 17'h01235) begin
      errors++;
      $display("FAIL acc_n1: pulses=%0d cyc=%0d to_reg=%h want 1/4/01235", pulses[1], first_cyc[1], val[1]);
    end
    checks++;
    if (pulses[2] !== 1 || first_cyc[2] !== 18 || val[2] !== 17'h01235) begin
      errors++;
      $display("FAIL acc_n15: pulses=%0d cyc=%0d to_reg=%h want 1/18/01235", pulses[2], first_cyc[2], val[2]);
    end
    checks++;
    if (busy_cnt !== 3 || ovf_w !== 3'b000) begin
      errors++;
      $display("FAIL acc_busy_ovf: busy_cycles=%0d ovf=%b want 3/000", busy_cnt, ovf_w);
    end
  endtask

  task automatic test_carry_ovf;
`ifdef ADDER_SAT_EN
    exp_v = 17'h1FFFF;
`else
    exp_v = 17'h10001;
`endif
    SW    = 16'h0002;
    Sum   = 16'h0001;
    C_out = 1'b1;
    press(1'b0, 1'b1, 20);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pulses[d] !== 1 || val[d] !== exp_v) begin
        errors++;
        $display("FAIL carry[%0d]: pulses=%0d to_reg=%h want 1/%h", d, pulses[d], val[d], exp_v);
      end
    end
    checks++;
    if (ovf_w !== 3'b111) begin
      errors++;
      $display("FAIL ovf_set: got %b want 111", ovf_w);
    end
    press(1'b1, 1'b0, 4);
    checks++;
    if (ovf_w !== 3'b000 || val[0] !== 17'h00002) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b to_reg=%h want 000/00002", ovf_w, val[0]);
    end
  endtask

  task automatic test_priority;
    SW    = 16'hBEEF;
    Sum   = 16'h5555;
    C_out = 1'b1;
    press(1'b1, 1'b1, 20);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pulses[d] !== 1 || first_cyc[d] !== 3 || val[d] !== 17'h0BEEF) begin
        errors++;
        $display("FAIL priority[%0d]: pulses=%0d cyc=%0d to_reg=%h want 1/3/0BEEF", d, pulses[d], first_cyc[d], val[d]);
      end
    end
    checks++;
    if (ovf_w !== 3'b000) begin
      errors++;
      $display("FAIL priority_ovf: got %b want 000", ovf_w);
    end
  endtask

  task automatic test_reset_mid_settle;
    Sum   = 16'h00AA;
    C_out = 1'b0;
    @(negedge Clk);
    Run = 1'b1;
    repeat (4) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    checks++;
    if (busy_w[0] !== 1'b1 || ld_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL settle_state: busy=%b ld=%b want 1/0", busy_w[0], ld_w[0]);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (ld_w !== 3'b000 || busy_w !== 3'b000 || treg_w[0] !== 17'h00000 || treg_w[1] !== 17'h00000) begin
      errors++;
      $display("FAIL async_reset: ld=%b busy=%b to_reg0=%h to_reg1=%h want zeros", ld_w, busy_w, treg_w[0], treg_w[1]);
    end
    Run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++;
      if (ld_w !== 3'b000 || busy_w !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold: ld=%b busy=%b want 000/000", ld_w, busy_w);
      end
    end
    Reset = 1'b0;
    prev_ld = '0;
    press(1'b0, 1'b1, 20);
    checks++;
    if (pulses[0] !== 1 || first_cyc[0] !== 5 || val[0] !== 17'h000AA) begin
      errors++;
      $display("FAIL after_reset: pulses=%0d cyc=%0d to_reg=%h want 1/5/000AA", pulses[0], first_cyc[0], val[0]);
    end
  endtask

  task automatic test_no_consecutive;
    checks++;
    if (consec[0] !== 0 || consec[1] !== 0 || consec[2] !== 0) begin
      errors++;
      $display("FAIL ld_consecutive: counts %0d/%0d/%0d want 0/0/0", consec[0], consec[1], consec[2]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_accumulate();
    test_carry_ovf();
    test_priority();
    test_reset_mid_settle();
    test_no_consecutive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Sequencing controller for the 16-bit carry-lookahead adder datapath. It synchronises the active-high LoadB and Run requests, which the datapath has already inverted from the push-buttons. It issues exactly one register load per button press: either a B load from the switches, or an accumulate that captures the adder sum and carry after a programmable settle window. It sits between the button/switch inputs and the 17-bit B register, and drives that register's load enable and data.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: cycles spent in SETTLE before capture; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- LoadB  in  1  active-high, asynchronous to Clk; request to load B from SW.
- Run  in  1  active-high, asynchronous to Clk; request to accumulate.
- SW  in  16  switch operand, taken as B on a load.
- Sum  in  16  adder sum output (A + B).
- C_out  in  1  adder carry output.
- Ld_B  out  1  load enable for the 17-bit B register.
- to_reg  out  17  data presented to the B register.
- busy  out  1  high in LOAD, SETTLE and CAPTURE.
- ovf  out  1  sticky carry/overflow flag.

## Operation
- Synchronisation: LoadB and Run each pass through a 2-flop synchroniser. The FSM uses only the synchronised copies, lb_s and run_s.
- States: IDLE, LOAD, SETTLE, CAPTURE, HOLD. Encoding is free.
- IDLE:
  - lb_s=1 -> LOAD. LoadB has priority when both requests are high in the same cycle.
  - Else run_s=1 -> SETTLE, with the counter loaded to SETTLE_CYCLES-1.
  - Else stay in IDLE.
- LOAD (1 cycle): Ld_B=1, to_reg={1'b0,SW}, ovf cleared at the exit edge. Next state HOLD.
- SETTLE:
  - Counter decrements each cycle; at 0 -> CAPTURE.
  - Ld_B=0. Run and LoadB are ignored.
- CAPTURE (1 cycle):
  - Ld_B=1, to_reg={C_out,Sum}.
  - C_out=1 sets ovf at the exit edge.
  - Next state HOLD.
- HOLD: stays until lb_s=0 and run_s=0, then -> IDLE. This guarantees one operation per press regardless of press length.
- Outside LOAD and CAPTURE: Ld_B=0, to_reg=17'h00000.
- Ld_B and to_reg are Moore outputs decoded from state; there is no combinational path from the request inputs.
- Arithmetic: the block does no addition. Bit 16 of to_reg carries C_out; the B register holds 17 bits, but only [15:0] feed back to the adder.
- Reset asserted (any state, including mid-SETTLE):
  - State -> IDLE, counter=0, synchronisers=0, ovf=0.
  - Ld_B=0, to_reg=0, busy=0, asynchronously.
  - No pending capture survives reset.
- Reset deasserted while a button is held: the press is treated as new. It is seen after 2 sync cycles.

## Timing
- Cycle numbering: edge n is the nth rising Clk edge with the input stable high before it. Reset is deasserted before edge 1.
- Load latency:
  - lb_s high after edge 2; state=LOAD after edge 3.
  - Ld_B high for cycle 3; B register updates at edge 4.
- Run latency:
  - State=SETTLE after edge 3 and stays SETTLE_CYCLES cycles.
  - CAPTURE after edge 3+SETTLE_CYCLES; B register updates at edge 4+SETTLE_CYCLES.
  - Default: capture at edge 6.
- Sum and C_out must be stable for the full SETTLE window. The block samples them only during CAPTURE.
- Ld_B is never high for two consecutive cycles.
- Minimum time between two operations: release plus 2 sync cycles plus 1 HOLD->IDLE cycle.

## Configuration
- Macro ADDER_SAT_EN.
- Defined: in CAPTURE with C_out=1, to_reg=17'h1FFFF (saturate; B becomes 0xFFFF). With C_out=0, to_reg={1'b0,Sum}.
- Undefined: CAPTURE always presents {C_out,Sum} (wrap-around).
- ovf behaviour is identical in both builds.

## Test plan
- Reset, then SW=16'h1234, pulse LoadB for 5 cycles -> Ld_B high for exactly 1 cycle (cycle 3), to_reg=17'h01234, ovf=0, busy high for cycle 3 only.
- B=16'h1234, Sum=16'h1235, C_out=0, Run held 20 cycles -> one Ld_B pulse at cycle 3+SETTLE_CYCLES, to_reg=17'h01235, no second pulse until Run released and re-pressed.
- Sum=16'h0001, C_out=1 (B=16'hFFFF, SW=16'h0002), press Run -> to_reg=17'h10001 without ADDER_SAT_EN, 17'h1FFFF with it; ovf=1 afterwards. A later LoadB press clears ovf.
- LoadB and Run rise on the same cycle -> LOAD path only: to_reg={0,SW}, no CAPTURE during the hold.
- Press Run, assert Reset during SETTLE -> Ld_B stays 0, outputs immediately 0, state IDLE. A new Run press after release completes normally.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=15 -> capture at edges 5 and 19 respectively.
